// File: rtl/axi_lite_arbiter_n.sv
// axi_lite_arbiter_n: N-master to 1-slave AXI-lite arbiter, one outstanding transaction at a time.
// Round-robin grant by default; defining ARB_FIXED_PRIO_EN gives strict lowest-index priority.
module axi_lite_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STRB_W      = 8,
  localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MASTERS-1:0]        m_arvalid,
  output logic [NUM_MASTERS-1:0]        m_arready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [1:0]                    m_rresp,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  input  logic [NUM_MASTERS-1:0]        m_rready,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
  input  logic [NUM_MASTERS-1:0]        m_awvalid,
  output logic [NUM_MASTERS-1:0]        m_awready,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]        m_wvalid,
  output logic [NUM_MASTERS-1:0]        m_wready,
  output logic [1:0]                    m_bresp,
  output logic [NUM_MASTERS-1:0]        m_bvalid,
  input  logic [NUM_MASTERS-1:0]        m_bready,
  output logic [ADDR_W-1:0]             s_araddr,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  output logic [ADDR_W-1:0]             s_awaddr,
  output logic                          s_awvalid,
  input  logic                          s_awready,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [STRB_W-1:0]             s_wstrb,
  output logic                          s_wvalid,
  input  logic                          s_wready,
  input  logic [1:0]                    s_bresp,
  input  logic                          s_bvalid,
  output logic                          s_bready,
  output logic                          busy,
  output logic [IDX_W-1:0]              grant_id
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_XFER = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [NUM_MASTERS-1:0] req_s;
  logic [IDX_W-1:0]       win_idx_s;
  logic                   aw_fin_s, w_fin_s;

  assign req_s = m_arvalid | m_awvalid;

  // Winner selection: scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    win_idx_s = {IDX_W{1'b0}};
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req_s[i]) begin
        win_idx_s = IDX_W'(i);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
`else
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (req_s[(int'(rr_ptr_q) + k) % NUM_MASTERS]) begin
        win_idx_s = IDX_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
`endif
  end

  // Next-state logic and ready/valid routing between the owner and the slave
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_fin_s  = 1'b0;
    w_fin_s   = 1'b0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_arready = {NUM_MASTERS{1'b0}};
    m_rvalid  = {NUM_MASTERS{1'b0}};
    m_awready = {NUM_MASTERS{1'b0}};
    m_wready  = {NUM_MASTERS{1'b0}};
    m_bvalid  = {NUM_MASTERS{1'b0}};
    case (state_q)
      IDLE: begin
        if (|req_s) begin
          grant_d = win_idx_s;
          state_d = m_arvalid[win_idx_s] ? RD_ADDR : WR_XFER;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        s_arvalid           = m_arvalid[grant_q];
        m_arready[grant_q]  = s_arready;
        if (m_arvalid[grant_q] && s_arready) begin
          state_d = RD_DATA;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_DATA: begin
        m_rvalid[grant_q] = s_rvalid;
        s_rready          = m_rready[grant_q];
        if (s_rvalid && m_rready[grant_q]) begin
          state_d = IDLE;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr_d = grant_q;
`endif
        end else begin
          state_d = RD_DATA;
        end
      end
      WR_XFER: begin
        // Each channel is masked once it has handshaken; the phase ends when both have
        s_awvalid          = m_awvalid[grant_q] & ~aw_done_q;
        m_awready[grant_q] = s_awready & ~aw_done_q;
        s_wvalid           = m_wvalid[grant_q] & ~w_done_q;
        m_wready[grant_q]  = s_wready & ~w_done_q;
        aw_fin_s           = aw_done_q | (m_awvalid[grant_q] & s_awready);
        w_fin_s            = w_done_q | (m_wvalid[grant_q] & s_wready);
        if (aw_fin_s && w_fin_s) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end else begin
          aw_done_d = aw_fin_s;
          w_done_d  = w_fin_s;
        end
      end
      WR_RESP: begin
        m_bvalid[grant_q] = s_bvalid;
        s_bready          = m_bready[grant_q];
        if (s_bvalid && m_bready[grant_q]) begin
          state_d = IDLE;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr_d = grant_q;
`endif
        end else begin
          state_d = WR_RESP;
        end
      end
      default: begin
        state_d   = IDLE;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
  end

  // State, grant and pointer registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= {IDX_W{1'b0}};
      rr_ptr_q  <= IDX_W'(NUM_MASTERS - 1);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign s_araddr = m_araddr[int'(grant_q)*ADDR_W +: ADDR_W];
  assign s_awaddr = m_awaddr[int'(grant_q)*ADDR_W +: ADDR_W];
  assign s_wdata  = m_wdata[int'(grant_q)*DATA_W +: DATA_W];
  assign s_wstrb  = m_wstrb[int'(grant_q)*STRB_W +: STRB_W];
  assign m_rdata  = s_rdata;
  assign m_rresp  = s_rresp;
  assign m_bresp  = s_bresp;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_axi_lite_arbiter_n.sv
// Self-checking bench for axi_lite_arbiter_n with three masters: directed scenarios plus
// randomized rounds checked against a transaction-order reference model.
module tb_axi_lite_arbiter_n;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst;
  logic [N*AW-1:0] m_araddr, m_awaddr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic [N-1:0]    m_wvalid, m_wready, m_bvalid, m_bready;
  logic [DW-1:0]   m_rdata, s_rdata, s_wdata;
  logic [1:0]      m_rresp, m_bresp, s_rresp, s_bresp;
  logic [AW-1:0]   s_araddr, s_awaddr;
  logic [SW-1:0]   s_wstrb;
  logic            s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic            s_wvalid, s_wready, s_bvalid, s_bready, busy;
  logic [1:0]      grant_id;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_ptr  = N - 1;

  axi_lite_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Reference arbitration rule: who is served next given the requesting set
  function automatic int arb_pick(input int ptr, input logic [N-1:0] mask);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (mask[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  task automatic clear_inputs();
    m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
    m_arvalid = '0; m_rready = '0; m_awvalid = '0; m_wvalid = '0; m_bready = '0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    m_arvalid = '1; m_awvalid = '1; m_wvalid = '1; m_rready = '1; m_bready = '1;
    s_rvalid = 1'b1; s_bvalid = 1'b1; s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, grant_id} !== 3'b000) begin
      n_fail++; $display("FAIL reset_busy_grant: got %b expected 000", {busy, grant_id});
    end
    n_checks++;
    if ({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_slave_side: got %b expected 00000",
                         {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready});
    end
    n_checks++;
    if ({m_arready, m_rvalid, m_awready, m_wready, m_bvalid} !== 15'd0) begin
      n_fail++; $display("FAIL reset_master_side: got %b expected 0",
                         {m_arready, m_rvalid, m_awready, m_wready, m_bvalid});
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    mdl_ptr = N - 1;
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_after_release: got %b expected 0", busy);
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m_araddr[1*AW +: AW] = 32'h8000_0010;
    m_arvalid = 3'b010; s_arready = 1'b1; m_rready = 3'b010;
    #1;
    n_checks++;
    if (s_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL sr_arb_cycle: s_arvalid got %b expected 0", s_arvalid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({s_arvalid, s_araddr, m_arready, grant_id} !== {1'b1, 32'h8000_0010, 3'b010, 2'd1}) begin
      n_fail++; $display("FAIL sr_addr_phase: got %b/%h/%b/%0d expected 1/80000010/010/1",
                         s_arvalid, s_araddr, m_arready, grant_id);
    end
    @(negedge clk);
    m_arvalid = 3'b000; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
    #1;
    n_checks++;
    if ({m_rvalid, m_rdata, m_rresp, s_rready} !== {3'b010, 32'hDEAD_BEEF, 2'b00, 1'b1}) begin
      n_fail++; $display("FAIL sr_data_phase: got %b/%h/%b/%b expected 010/deadbeef/00/1",
                         m_rvalid, m_rdata, m_rresp, s_rready);
    end
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    n_checks++;
    if ({busy, grant_id} !== {1'b0, 2'd1}) begin
      n_fail++; $display("FAIL sr_back_to_idle: got %b/%0d expected 0/1", busy, grant_id);
    end
    mdl_ptr = 1;
    clear_inputs();
  endtask

  task automatic test_split_write();
    @(negedge clk);
    m_awaddr[2*AW +: AW] = 32'h0000_1000;
    m_wdata[2*DW +: DW]  = 32'h1234_5678;
    m_wstrb[2*SW +: SW]  = 8'h0F;
    m_awvalid = 3'b100; m_wvalid = 3'b100; m_bready = 3'b100;
    s_awready = 1'b1; s_wready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({s_awvalid, s_awaddr, m_awready, s_wvalid, m_wready, grant_id} !==
        {1'b1, 32'h0000_1000, 3'b100, 1'b1, 3'b000, 2'd2}) begin
      n_fail++; $display("FAIL wr_aw_phase: got %b/%h/%b/%b/%b/%0d expected 1/00001000/100/1/000/2",
                         s_awvalid, s_awaddr, m_awready, s_wvalid, m_wready, grant_id);
    end
    @(negedge clk);
    s_bvalid = 1'b1; s_bresp = 2'b10;
    #1;
    n_checks++;
    if ({s_awvalid, m_awready} !== 4'b0000) begin
      n_fail++; $display("FAIL wr_aw_masked: got %b/%b expected 0/000", s_awvalid, m_awready);
    end
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if ({m_bvalid, s_bready, busy, s_wvalid} !== {3'b000, 1'b0, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL wr_wait_w_%0d: got %b/%b/%b/%b expected 000/0/1/1",
                           c, m_bvalid, s_bready, busy, s_wvalid);
      end
      @(negedge clk);
      #1;
    end
    s_wready = 1'b1;
    #1;
    n_checks++;
    if ({s_wdata, s_wstrb, m_wready, s_bready} !== {32'h1234_5678, 8'h0F, 3'b100, 1'b0}) begin
      n_fail++; $display("FAIL wr_w_phase: got %h/%h/%b/%b expected 12345678/0f/100/0",
                         s_wdata, s_wstrb, m_wready, s_bready);
    end
    @(negedge clk);
    s_wready = 1'b0; m_awvalid = 3'b000; m_wvalid = 3'b000;
    #1;
    n_checks++;
    if ({m_bvalid, m_bresp, s_bready, s_wvalid, s_awvalid} !== {3'b100, 2'b10, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL wr_resp_phase: got %b/%b/%b/%b/%b expected 100/10/1/0/0",
                         m_bvalid, m_bresp, s_bready, s_wvalid, s_awvalid);
    end
    @(negedge clk);
    s_bvalid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL wr_back_to_idle: got %b expected 0", busy);
    end
    mdl_ptr = 2;
    clear_inputs();
  endtask

  task automatic test_rr_order();
    int got, last_cyc, exp_m, ptr;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    for (int i = 0; i < N; i++) m_araddr[i*AW +: AW] = 32'hA000_0000 + 32'(i * 16);
    m_arvalid = '1; m_rready = '1; s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D;
    ptr = mdl_ptr; got = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      #1;
      if (s_arvalid && s_arready) begin
        exp_m = arb_pick(ptr, 3'b111);
        exp_addr = 32'hA000_0000 + 32'(exp_m * 16);
        n_checks++;
        if ({s_araddr, grant_id} !== {exp_addr, 2'(exp_m)}) begin
          n_fail++; $display("FAIL rr_grant_%0d: got %h/%0d expected %h/%0d",
                             got, s_araddr, grant_id, exp_addr, exp_m);
        end
        if (got > 0) begin
          n_checks++;
          if (cyc - last_cyc !== 3) begin
            n_fail++; $display("FAIL rr_period_%0d: got %0d expected 3", got, cyc - last_cyc);
          end
        end
        last_cyc = cyc; ptr = exp_m; got++;
      end
      if (got < 4) @(negedge clk);
    end
    n_checks++;
    if (got !== 4) begin
      n_fail++; $display("FAIL rr_timeout: got %0d grants expected 4", got);
    end
    @(negedge clk);
    m_arvalid = '0;
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rr_drain: busy got %b expected 0", busy);
    end
    mdl_ptr = ptr;
    clear_inputs();
  endtask

  task automatic test_random(input int rounds);
    logic [N-1:0]  ar_pend, aw_pend, w_pend, rd_left, wr_left, oh;
    logic [N-1:0]  m_ar_hs, m_aw_hs, m_w_hs;
    logic [AW-1:0] a_rd [N];
    logic [AW-1:0] a_wr [N];
    logic [DW-1:0] wd [N];
    logic [SW-1:0] ws [N];
    logic [1:0]    op;
    logic [AW-1:0] sl_rd_addr, sl_aw_addr, cap_ar, cap_aw;
    logic          sl_rd_pend, sl_aw_got, sl_w_got, exp_wr;
    logic          ev_ar, ev_aw, ev_w, ev_r, ev_b;
    int            expq[$];
    int            ptr, m, budget;
    for (int r = 0; r < rounds; r++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        op = 2'($urandom_range(0, 3));
        ar_pend[i] = op[0]; aw_pend[i] = op[1]; w_pend[i] = op[1];
        a_rd[i] = $urandom; a_wr[i] = $urandom; wd[i] = $urandom; ws[i] = 8'($urandom);
        m_araddr[i*AW +: AW] = a_rd[i]; m_awaddr[i*AW +: AW] = a_wr[i];
        m_wdata[i*DW +: DW] = wd[i]; m_wstrb[i*SW +: SW] = ws[i];
      end
      // Expected service order: reads before writes per master, masters in arbitration order
      rd_left = ar_pend; wr_left = aw_pend; ptr = mdl_ptr; expq.delete();
      while ((rd_left | wr_left) != '0) begin
        m = arb_pick(ptr, rd_left | wr_left);
        if (rd_left[m]) begin expq.push_back(m * 2); rd_left[m] = 1'b0; end
        else begin expq.push_back(m * 2 + 1); wr_left[m] = 1'b0; end
        ptr = m;
      end
      mdl_ptr = ptr;
      sl_rd_pend = 1'b0; sl_aw_got = 1'b0; sl_w_got = 1'b0;
      sl_rd_addr = '0; sl_aw_addr = '0;
      budget = 0;
      while (expq.size() > 0 && budget < 1000) begin
        m_arvalid = ar_pend; m_awvalid = aw_pend; m_wvalid = w_pend;
        m_rready = N'($urandom); m_bready = N'($urandom);
        s_arready = !sl_rd_pend && ($urandom_range(0, 1) == 1);
        s_awready = !sl_aw_got && ($urandom_range(0, 1) == 1);
        s_wready  = !sl_w_got && ($urandom_range(0, 1) == 1);
        if (sl_rd_pend && !s_rvalid && $urandom_range(0, 2) != 0) begin
          s_rvalid = 1'b1; s_rdata = sl_rd_addr ^ 32'h5A5A_0F0F; s_rresp = sl_rd_addr[3:2];
        end
        if (sl_aw_got && sl_w_got && !s_bvalid && $urandom_range(0, 2) != 0) begin
          s_bvalid = 1'b1; s_bresp = sl_aw_addr[5:4];
        end
        #1;
        m = expq[0] / 2;
        exp_wr = (expq[0] % 2) == 1;
        oh = N'(1) << m;
        n_checks++;
        if (((m_arready | m_awready | m_wready | m_rvalid | m_bvalid) & ~oh) !== '0) begin
          n_fail++; $display("FAIL rnd_isolation r%0d: got ar%b aw%b w%b r%b b%b owner mask %b",
                             r, m_arready, m_awready, m_wready, m_rvalid, m_bvalid, oh);
        end
        ev_ar = s_arvalid & s_arready; ev_aw = s_awvalid & s_awready; ev_w = s_wvalid & s_wready;
        ev_r = s_rvalid & s_rready; ev_b = s_bvalid & s_bready;
        m_ar_hs = m_arvalid & m_arready; m_aw_hs = m_awvalid & m_awready; m_w_hs = m_wvalid & m_wready;
        cap_ar = s_araddr; cap_aw = s_awaddr;
        if (ev_ar) begin
          n_checks++;
          if ({exp_wr, s_araddr} !== {1'b0, a_rd[m]}) begin
            n_fail++; $display("FAIL rnd_ar r%0d: got wr=%b addr %h expected wr=0 addr %h (m%0d)",
                               r, exp_wr, s_araddr, a_rd[m], m);
          end
        end
        if (ev_aw) begin
          n_checks++;
          if ({exp_wr, s_awaddr} !== {1'b1, a_wr[m]}) begin
            n_fail++; $display("FAIL rnd_aw r%0d: got wr=%b addr %h expected wr=1 addr %h (m%0d)",
                               r, exp_wr, s_awaddr, a_wr[m], m);
          end
        end
        if (ev_w) begin
          n_checks++;
          if ({s_wdata, s_wstrb} !== {wd[m], ws[m]}) begin
            n_fail++; $display("FAIL rnd_w r%0d: got %h/%h expected %h/%h",
                               r, s_wdata, s_wstrb, wd[m], ws[m]);
          end
        end
        if (ev_r) begin
          n_checks++;
          if ({exp_wr, m_rvalid, m_rdata, m_rresp} !==
              {1'b0, oh, a_rd[m] ^ 32'h5A5A_0F0F, a_rd[m][3:2]}) begin
            n_fail++; $display("FAIL rnd_r r%0d: got %b/%h/%b expected %b/%h/%b",
                               r, m_rvalid, m_rdata, m_rresp, oh, a_rd[m] ^ 32'h5A5A_0F0F, a_rd[m][3:2]);
          end
        end
        if (ev_b) begin
          n_checks++;
          if ({exp_wr, m_bvalid, m_bresp} !== {1'b1, oh, a_wr[m][5:4]}) begin
            n_fail++; $display("FAIL rnd_b r%0d: got %b/%b expected %b/%b",
                               r, m_bvalid, m_bresp, oh, a_wr[m][5:4]);
          end
        end
        @(negedge clk);
        ar_pend &= ~m_ar_hs; aw_pend &= ~m_aw_hs; w_pend &= ~m_w_hs;
        if (ev_ar) begin sl_rd_pend = 1'b1; sl_rd_addr = cap_ar; end
        if (ev_aw) begin sl_aw_got = 1'b1; sl_aw_addr = cap_aw; end
        if (ev_w) sl_w_got = 1'b1;
        if (ev_r) begin sl_rd_pend = 1'b0; s_rvalid = 1'b0; void'(expq.pop_front()); end
        if (ev_b) begin sl_aw_got = 1'b0; sl_w_got = 1'b0; s_bvalid = 1'b0; void'(expq.pop_front()); end
        budget++;
      end
      n_checks++;
      if (budget >= 1000) begin
        n_fail++; $display("FAIL rnd_timeout r%0d: %0d transactions left expected 0", r, expq.size());
      end
      m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL rnd_idle_end r%0d: busy got %b expected 0", r, busy);
      end
      clear_inputs();
    end
  endtask

  task automatic test_reset_mid();
    int exp_m;
    @(negedge clk);
    m_araddr[1*AW +: AW] = 32'h0000_2000;
    m_arvalid = 3'b010; s_arready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_arvalid = 3'b000; s_arready = 1'b0; m_rready = 3'b010;
    s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001;
    #1;
    n_checks++;
    if ({m_rvalid, s_rready, busy} !== {3'b010, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rm_in_rdata: got %b/%b/%b expected 010/1/1", m_rvalid, s_rready, busy);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({m_rvalid, m_arready, m_awready, m_wready, m_bvalid, s_rready, s_arvalid, s_awvalid,
         s_wvalid, s_bready, busy, grant_id} !== 23'd0) begin
      n_fail++; $display("FAIL rm_async_clear: got r%b s_rready%b busy%b grant%0d expected all 0",
                         m_rvalid, s_rready, busy, grant_id);
    end
    s_rvalid = 1'b0; m_rready = '0;
    for (int i = 0; i < N; i++) m_araddr[i*AW +: AW] = 32'hB000_0000 + 32'(i * 4);
    m_arvalid = '1;
    @(negedge clk);
    rst = 1'b1;
    mdl_ptr = N - 1;
    exp_m = arb_pick(mdl_ptr, 3'b111);
    @(negedge clk);
    #1;
    n_checks++;
    if ({s_arvalid, grant_id, s_araddr} !== {1'b1, 2'(exp_m), 32'hB000_0000 + 32'(exp_m * 4)}) begin
      n_fail++; $display("FAIL rm_first_grant: got %b/%0d/%h expected 1/%0d/%h",
                         s_arvalid, grant_id, s_araddr, exp_m, 32'hB000_0000 + 32'(exp_m * 4));
    end
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    mdl_ptr = N - 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_split_write();
    test_rr_order();
    test_random(25);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter_n.md
Name: axi_lite_arbiter_n

Overview:
N-master to 1-slave AXI-lite arbiter, the parametrised successor of the two-master (IFU/LSU) arbiter in the multicycle core. It serialises read and write transactions from NUM_MASTERS masters onto a single memory port, one outstanding transaction at a time. Grants are round-robin, with a fixed-priority build option. It sits between the fetch/load-store/DMA-style masters and the memory-side slave.

Parameters:
NUM_MASTERS, 2, number of master ports (>=2)
ADDR_W, 32, address width
DATA_W, 32, data width
STRB_W, 8, write-strobe width (matches current lsu wstrb)
IDX_W, $clog2(NUM_MASTERS), grant index width (derived, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
m_araddr  in  NUM_MASTERS*ADDR_W  master read address, master i at [i*ADDR_W +: ADDR_W]
m_arvalid  in  NUM_MASTERS  per-master AR valid
m_arready  out  NUM_MASTERS  per-master AR ready
m_rdata  out  DATA_W  read data, broadcast to all masters
m_rresp  out  2  read response, broadcast
m_rvalid  out  NUM_MASTERS  per-master R valid
m_rready  in  NUM_MASTERS  per-master R ready
m_awaddr  in  NUM_MASTERS*ADDR_W  master write address
m_awvalid  in  NUM_MASTERS  per-master AW valid
m_awready  out  NUM_MASTERS  per-master AW ready
m_wdata  in  NUM_MASTERS*DATA_W  master write data
m_wstrb  in  NUM_MASTERS*STRB_W  master write strobe
m_wvalid  in  NUM_MASTERS  per-master W valid
m_wready  out  NUM_MASTERS  per-master W ready
m_bresp  out  2  write response, broadcast
m_bvalid  out  NUM_MASTERS  per-master B valid
m_bready  in  NUM_MASTERS  per-master B ready
s_araddr/s_arvalid/s_arready, s_rdata/s_rresp/s_rvalid/s_rready, s_awaddr/s_awvalid/s_awready, s_wdata/s_wstrb/s_wvalid/s_wready, s_bresp/s_bvalid/s_bready  slave side, widths as master single channel, directions mirrored
busy  out  1  high in any state other than IDLE
grant_id  out  IDX_W  index of the current owner; valid while busy

Behaviour:
- Reset (rst=0, async): state=IDLE, grant_id=0, rr_ptr=NUM_MASTERS-1 so master 0 wins first. All m_*ready/m_*valid and s_*valid/s_*ready are 0.
- Request per master: req[i] = m_arvalid[i] | m_awvalid[i].
- States: IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP.
- IDLE: if any req, register grant = first requester scanning from rr_ptr+1 upward, with wrap modulo NUM_MASTERS.
  - Go to RD_ADDR if that master's arvalid=1, else WR_XFER. Read wins when the owner asserts both.
  - Arbitration takes 1 cycle: the earliest slave-side valid is the cycle after the request is first seen.
- RD_ADDR: s_araddr/s_arvalid come from the owner; m_arready[owner]=s_arready, all others 0. On handshake, go to RD_DATA.
- RD_DATA: m_rvalid[owner]=s_rvalid; s_rready=m_rready[owner]. On handshake, go to IDLE and set rr_ptr=owner.
- WR_XFER: AW and W are forwarded independently from the owner.
  - Sticky flags aw_done/w_done mask the respective valid after its handshake.
  - When both are done (same or different cycles), clear the flags and go to WR_RESP.
- WR_RESP: m_bvalid[owner]=s_bvalid; s_bready=m_bready[owner]. On handshake, go to IDLE and set rr_ptr=owner.
- Non-owners always see ready/valid = 0. Slave valids outside their phase are ignored (the matching ready is held 0).
- rresp/bresp are passed through unmodified, including error responses.
- A master dropping valid after grant (AXI violation) is not recovered: the state holds until the handshake.
- Reset mid-transaction aborts to IDLE immediately. No slave-side valid may remain asserted after reset.
- Back-to-back: a new grant is at earliest 1 cycle after the final handshake; the IDLE cycle is mandatory.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: the grant is the lowest-index requester; rr_ptr is not updated. Master 0 (IFU) has strict priority.
- Undefined: round-robin as above.

Test Plan:
- Single read: master 1 arvalid, araddr=0x80000010; slave returns rdata=0xDEADBEEF, rresp=0 -> s_arvalid rises 1 cycle later; m_rvalid=0b10 only; rdata matches; back to IDLE; grant_id=1.
- Round-robin, N=3: all three assert arvalid continuously, slave with zero wait -> grant order 0,1,2,0; each transaction takes 3 cycles (IDLE, AR, R).
- Write with split channels: AW handshakes cycle t, W handshakes t+3 (wstrb=0x0F, wdata=0x12345678) -> s_awvalid low after t; WR_RESP entered only after t+3; bresp=2 (SLVERR) forwarded to owner only.
- Owner asserts arvalid and awvalid together -> read completes first, then the same master is served its write only after the other masters have had a turn (round-robin).
- Reset asserted during RD_DATA with s_rvalid=1 -> all outputs 0 asynchronously; after release, the first grant goes to master 0.
- With ARB_FIXED_PRIO_EN: masters 0 and 2 requesting continuously -> master 2 never granted while master 0 requests.
